keypad_scan: RTL



---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_sync.sv | 28 ++
 rtl/keypad_scan.sv | 133 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        RELEASE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } col_hit_t;

    localparam logic [3:0] ROW_RESET = 4'b1110;
    localparam logic [3:0] COL_IDLE  = 4'hF;

    // Nibble {r,c} holds the hex code of the key at row r, column c.
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    function automatic col_hit_t onehot0_idx(input logic [3:0] col);
        col_hit_t hit;
        int       zeros;
        hit   = '0;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!col[i]) begin
                zeros++;
                hit.idx = 2'(i);
            end
        end
        hit.valid = (zeros == 1);
        return hit;
    endfunction

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] base;
        base = {r, c, 2'b00};
        return KEY_MAP[base +: 4];
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
module keypad_sync #(
    parameter int             W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: non-blocking assignments make the two stages a true shift; blocking would collapse them into one flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row drive, debounce, hex encode and a 32-bit digit shift register.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100_000,
    parameter int DEBOUNCE_TICKS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  row,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [31:0] data
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_CYCLES - 1);
    localparam logic [DW-1:0] DBC_LAST = DW'(DEBOUNCE_TICKS - 1);

    logic [3:0]    col_s;
    logic          tick;
    logic          accept;
    col_hit_t      hit;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    r_q, r_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] dbc_q, dbc_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [31:0]   data_q, data_d;

    keypad_sync #(.W(4), .RESET_VAL(COL_IDLE)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col),
        .q   (col_s)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        tick        = (cnt_q == CNT_MAX);
        hit         = onehot0_idx(col_s);
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        state_d     = state_q;
        r_d         = r_q;
        cand_d      = cand_q;
        dbc_d       = dbc_q;
        accept      = 1'b0;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;

        case (state_q)
            SCAN: if (tick) begin
                if (hit.valid) begin
                    cand_d  = col_s;
                    dbc_d   = '0;
                    state_d = DEBOUNCE;
                end else begin
                    r_d = r_q + 2'd1;
                end
            end
            DEBOUNCE: if (tick) begin
                if (col_s == cand_q) begin
                    if (dbc_q == DBC_LAST) begin
                        accept  = 1'b1;
                        dbc_d   = '0;
                        state_d = RELEASE;
                    end else begin
                        dbc_d = dbc_q + DW'(1);
                    end
                end else begin
                    state_d = SCAN;
                    r_d     = r_q + 2'd1;
                end
            end
            RELEASE: if (tick) begin
                if (col_s == COL_IDLE) begin
                    if (dbc_q == DBC_LAST) begin
                        dbc_d   = '0;
                        state_d = SCAN;
                        r_d     = r_q + 2'd1;
                    end else begin
                        dbc_d = dbc_q + DW'(1);
                    end
                end else begin
                    dbc_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase

        // Clear applies before the shift, so a coincident accept lands on an empty register.
        data_d = clr ? '0 : data_q;
        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = key_lookup(r_q, hit.idx);
            data_d      = {data_d[27:0], key_code_d};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            r_q         <= '0;
            cand_q      <= COL_IDLE;
            dbc_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            cand_q      <= cand_d;
            dbc_q       <= dbc_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            data_q      <= data_d;
        end
    end

    assign row       = ~(~ROW_RESET << r_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign data      = data_q;

endmodule
